// File: rtl/jump_controller.sv
// Frame-stepped jump arc for the player character, with a block-map landing check, a fall-to-floor sequence and a saturating jump counter.
// Commands are taken only in IDLE; commands that arrive while busy are dropped. All outputs are registered, so they change on the cycle after the event.
module jump_controller #(
    parameter int N_COLS     = 8,
    parameter int COL_WIDTH  = 64,
    parameter int X_ORIGIN   = 128,
    parameter int START_COL  = 0,
    parameter int Y_GROUND   = 400,
    parameter int Y_FLOOR    = 568,
    parameter int JUMP_STEPS = 16,
    parameter int V_STEP     = 4,
    parameter int FALL_STEP  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_init,
    input  logic              i_frame_tick,
    input  logic              i_jump_left,
    input  logic              i_jump_right,
    input  logic [N_COLS-1:0] i_block_map,
    output logic [10:0]       o_char_xpos,
    output logic [10:0]       o_char_ypos,
    output logic [3:0]        o_char_col,
    output logic              o_character_landed,
    output logic              o_jump_fail,
    output logic [7:0]        o_jump_count,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RISE,
        S_DESCEND,
        S_LAND,
        S_FALL,
        S_DEAD
    } state_t;

    localparam logic [10:0] X_STEP  = 11'(COL_WIDTH / JUMP_STEPS);
    localparam logic [10:0] V_INC   = 11'(V_STEP);
    localparam logic [10:0] F_INC   = 11'(FALL_STEP);
    localparam logic [10:0] Y_GND   = 11'(Y_GROUND);
    localparam logic [10:0] Y_FLR   = 11'(Y_FLOOR);
    localparam logic [10:0] X_START = 11'(X_ORIGIN + START_COL * COL_WIDTH);
    localparam logic [3:0]  C_START = 4'(START_COL);
    localparam logic [4:0]  N_COLS5 = 5'(N_COLS);
    localparam logic [7:0]  HALF_M1 = 8'(JUMP_STEPS / 2 - 1);

    state_t      r_state, w_state;
    logic [10:0] r_x, w_x;
    logic [10:0] r_y, w_y;
    logic [3:0]  r_col, w_col;
    logic [4:0]  r_target, w_target;
    logic        r_dir, w_dir;
    logic [7:0]  r_step, w_step;
    logic        r_landed, w_landed;
    logic        r_fail, w_fail;
    logic [7:0]  r_count, w_count;
    logic        r_busy, w_busy;

    logic [15:0] w_map_ext;
    logic        w_hit;
    logic [10:0] w_x_arc;
    logic [10:0] w_y_fall;

    // Target is a 5-bit two's-complement column: bit 4 set means column -1.
    assign w_map_ext = 16'(i_block_map);
    assign w_hit     = !r_target[4] && (r_target < N_COLS5) && w_map_ext[r_target[3:0]];
    assign w_x_arc   = r_dir ? (r_x + X_STEP) : (r_x - X_STEP);
    assign w_y_fall  = r_y + F_INC;

    always_comb begin
        w_state  = r_state;
        w_x      = r_x;
        w_y      = r_y;
        w_col    = r_col;
        w_target = r_target;
        w_dir    = r_dir;
        w_step   = r_step;
        w_landed = 1'b0;
        w_fail   = r_fail;
        w_count  = r_count;

        case (r_state)
            S_IDLE: begin
                if ((i_jump_left ^ i_jump_right) && !r_fail) begin
                    w_dir    = i_jump_right;
                    w_target = i_jump_right ? ({1'b0, r_col} + 5'd1) : ({1'b0, r_col} - 5'd1);
                    w_step   = 8'd0;
                    w_state  = S_RISE;
                end
            end
            S_RISE: begin
                if (i_frame_tick) begin
                    w_x = w_x_arc;
                    w_y = r_y - V_INC;
                    if (r_step == HALF_M1) begin
                        w_step  = 8'd0;
                        w_state = S_DESCEND;
                    end else begin
                        w_step = r_step + 8'd1;
                    end
                end
            end
            S_DESCEND: begin
                if (i_frame_tick) begin
                    w_x = w_x_arc;
                    w_y = r_y + V_INC;
                    if (r_step == HALF_M1) begin
                        w_step   = 8'd0;
                        w_landed = 1'b1;
                        w_state  = S_LAND;
                    end else begin
                        w_step = r_step + 8'd1;
                    end
                end
            end
            S_LAND: begin
                if (w_hit) begin
                    w_col   = r_target[3:0];
                    w_y     = Y_GND;
                    w_count = (r_count == 8'hFF) ? r_count : (r_count + 8'd1);
                    w_state = S_IDLE;
                end else begin
                    w_fail  = 1'b1;
                    w_state = S_FALL;
                end
            end
            S_FALL: begin
                // Landed pulse fires one cycle after the floor is reached.
                if (r_y == Y_FLR) begin
                    w_landed = 1'b1;
                    w_state  = S_DEAD;
                end else if (i_frame_tick) begin
                    w_y = (w_y_fall > Y_FLR) ? Y_FLR : w_y_fall;
                end
            end
            S_DEAD: begin
                w_state = S_DEAD;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state == S_RISE) || (w_state == S_DESCEND) || (w_state == S_FALL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_init) begin
            r_state  <= S_IDLE;
            r_x      <= X_START;
            r_y      <= Y_GND;
            r_col    <= C_START;
            r_target <= {1'b0, C_START};
            r_dir    <= 1'b0;
            r_step   <= 8'd0;
            r_landed <= 1'b0;
            r_fail   <= 1'b0;
            r_count  <= 8'd0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_x      <= w_x;
            r_y      <= w_y;
            r_col    <= w_col;
            r_target <= w_target;
            r_dir    <= w_dir;
            r_step   <= w_step;
            r_landed <= w_landed;
            r_fail   <= w_fail;
            r_count  <= w_count;
            r_busy   <= w_busy;
        end
    end

    assign o_char_xpos        = r_x;
    assign o_char_ypos        = r_y;
    assign o_char_col         = r_col;
    assign o_character_landed = r_landed;
    assign o_jump_fail        = r_fail;
    assign o_jump_count       = r_count;
    assign o_busy             = r_busy;

endmodule

// File: tb/tb_jump_controller.sv
// Directed bench for jump_controller: a vector table of jump scenarios, then hand-written
// sequences for dropped commands, init/reset abort, a tick during LAND and count saturation.
module tb_jump_controller;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_init;
    logic        i_frame_tick;
    logic        i_jump_left;
    logic        i_jump_right;
    logic [7:0]  i_block_map;
    logic [10:0] o_char_xpos;
    logic [10:0] o_char_ypos;
    logic [3:0]  o_char_col;
    logic        o_character_landed;
    logic        o_jump_fail;
    logic [7:0]  o_jump_count;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    int landed_cnt = 0;
    logic prev_landed = 1'b0;

    jump_controller dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_init             (i_init),
        .i_frame_tick       (i_frame_tick),
        .i_jump_left        (i_jump_left),
        .i_jump_right       (i_jump_right),
        .i_block_map        (i_block_map),
        .o_char_xpos        (o_char_xpos),
        .o_char_ypos        (o_char_ypos),
        .o_char_col         (o_char_col),
        .o_character_landed (o_character_landed),
        .o_jump_fail        (o_jump_fail),
        .o_jump_count       (o_jump_count),
        .o_busy             (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_character_landed === 1'b1) begin
            landed_cnt++;
            checks++;
            if (prev_landed === 1'b1) begin
                errors++;
                $display("FAIL landed_consecutive: got two pulses in a row, required isolated pulses");
            end
        end
        prev_landed <= o_character_landed;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_tick();
        i_frame_tick = 1'b1;
        cyc();
        i_frame_tick = 1'b0;
        cyc();
    endtask

    task automatic cmd(input logic l, input logic r);
        i_jump_left  = l;
        i_jump_right = r;
        cyc();
        i_jump_left  = 1'b0;
        i_jump_right = 1'b0;
    endtask

    task automatic full_jump(input logic r);
        cmd(!r, r);
        repeat (16) pulse_tick();
        cyc();
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int col,
                           input int fail, input int cnt, input int busy);
        chk({tag, ".x"},     32'(o_char_xpos),  32'(x));
        chk({tag, ".y"},     32'(o_char_ypos),  32'(y));
        chk({tag, ".col"},   32'(o_char_col),   32'(col));
        chk({tag, ".fail"},  32'(o_jump_fail),  32'(fail));
        chk({tag, ".count"}, 32'(o_jump_count), 32'(cnt));
        chk({tag, ".busy"},  32'(o_busy),       32'(busy));
    endtask

    typedef struct {
        bit         do_init;
        logic [7:0] map;
        logic [1:0] cmd;     // [1]=left, [0]=right
        int         ticks;
        int         x, y, col, fail, cnt, busy, landed;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    initial begin
        int base;
        vecs[0]  = '{0, 8'hFF, 2'b00, 0,  128, 400, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 8'hFF, 2'b01, 8,  160, 368, 0, 0, 0, 1, 0};
        vecs[2]  = '{0, 8'hFF, 2'b00, 8,  192, 400, 1, 0, 1, 0, 1};
        vecs[3]  = '{0, 8'hFF, 2'b00, 3,  192, 400, 1, 0, 1, 0, 0};
        vecs[4]  = '{0, 8'hFF, 2'b11, 4,  192, 400, 1, 0, 1, 0, 0};
        vecs[5]  = '{0, 8'hFF, 2'b10, 16, 128, 400, 0, 0, 2, 0, 1};
        vecs[6]  = '{1, 8'hFF, 2'b00, 0,  128, 400, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 8'hFD, 2'b01, 16, 192, 400, 0, 1, 0, 1, 1};
        vecs[8]  = '{0, 8'hFD, 2'b00, 21, 192, 568, 0, 1, 0, 0, 1};
        vecs[9]  = '{0, 8'hFF, 2'b01, 16, 192, 568, 0, 1, 0, 0, 0};
        vecs[10] = '{1, 8'hFF, 2'b00, 0,  128, 400, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 8'hFF, 2'b10, 16, 64,  400, 0, 1, 0, 1, 1};
        vecs[12] = '{0, 8'hFF, 2'b00, 21, 64,  568, 0, 1, 0, 0, 1};
        vecs[13] = '{0, 8'hFF, 2'b01, 16, 64,  568, 0, 1, 0, 0, 0};

        i_rst = 1'b1; i_init = 1'b0; i_frame_tick = 1'b0;
        i_jump_left = 1'b0; i_jump_right = 1'b0; i_block_map = 8'hFF;
        repeat (3) cyc();
        i_rst = 1'b0;
        cyc();
        chk("reset.landed", 32'(o_character_landed), 32'd0);

        for (int i = 0; i < NV; i++) begin
            base = landed_cnt;
            i_block_map = vecs[i].map;
            if (vecs[i].do_init) begin
                i_init = 1'b1;
                cyc();
                i_init = 1'b0;
            end
            if (vecs[i].cmd != 2'b00) cmd(vecs[i].cmd[1], vecs[i].cmd[0]);
            repeat (vecs[i].ticks) pulse_tick();
            cyc();
            cyc();
            chk_pos($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].col,
                    vecs[i].fail, vecs[i].cnt, vecs[i].busy);
            chk($sformatf("vec%0d.landed_pulses", i), 32'(landed_cnt - base), 32'(vecs[i].landed));
        end

        // Second command during RISE is dropped, not queued.
        i_init = 1'b1; cyc(); i_init = 1'b0;
        i_block_map = 8'hFF;
        base = landed_cnt;
        cmd(1'b0, 1'b1);
        chk("drop.busy_after_cmd", 32'(o_busy), 32'd1);
        repeat (3) pulse_tick();
        chk("drop.x_tick3", 32'(o_char_xpos), 32'd140);
        chk("drop.y_tick3", 32'(o_char_ypos), 32'd388);
        cmd(1'b0, 1'b1);
        repeat (13) pulse_tick();
        cyc();
        chk_pos("drop.end", 192, 400, 1, 0, 1, 0);
        repeat (16) pulse_tick();
        chk("drop.x_no_requeue", 32'(o_char_xpos), 32'd192);
        chk("drop.landed_pulses", 32'(landed_cnt - base), 32'd1);

        // init mid-jump aborts cleanly.
        full_jump(1'b1);
        chk("abort.count_before", 32'(o_jump_count), 32'd2);
        base = landed_cnt;
        cmd(1'b0, 1'b1);
        repeat (5) pulse_tick();
        i_init = 1'b1; cyc(); i_init = 1'b0;
        chk_pos("abort_init", 128, 400, 0, 0, 0, 0);
        repeat (10) pulse_tick();
        chk("abort_init.x_still", 32'(o_char_xpos), 32'd128);
        chk("abort_init.landed_pulses", 32'(landed_cnt - base), 32'd0);

        // rst mid-jump behaves the same way.
        full_jump(1'b1);
        base = landed_cnt;
        cmd(1'b0, 1'b1);
        repeat (5) pulse_tick();
        i_rst = 1'b1; cyc(); i_rst = 1'b0;
        chk_pos("abort_rst", 128, 400, 0, 0, 0, 0);
        repeat (4) pulse_tick();
        chk("abort_rst.landed_pulses", 32'(landed_cnt - base), 32'd0);

        // Frame tick held through the LAND cycle must not disturb the landing.
        cmd(1'b0, 1'b1);
        repeat (15) pulse_tick();
        i_frame_tick = 1'b1; cyc(); cyc(); i_frame_tick = 1'b0;
        cyc();
        chk_pos("landtick", 192, 400, 1, 0, 1, 0);
        full_jump(1'b0);
        chk_pos("landtick.next", 128, 400, 0, 0, 2, 0);

        // Jump count saturation.
        i_init = 1'b1; cyc(); i_init = 1'b0;
        for (int j = 0; j < 255; j++) full_jump(j[0] == 1'b0);
        chk("sat.count_255", 32'(o_jump_count), 32'd255);
        chk("sat.col_255", 32'(o_char_col), 32'd1);
        full_jump(1'b0);
        chk("sat.count_256", 32'(o_jump_count), 32'd255);
        chk("sat.x_256", 32'(o_char_xpos), 32'd128);
        chk("sat.fail", 32'(o_jump_fail), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
